// File: rtl/bus_codes_pkg.sv
// Shared bus codes for the register-transfer sequencer: source and
// destination code tables, the number of legal codes and the FSM states.
package bus_codes_pkg;

  localparam int N_BUS_CODES = 24;
  localparam int CODE_W      = 5;

  typedef logic [CODE_W-1:0] code_t;

  // Bus sources (out enables). Rn is SRC_R0 + n for n in 0..15.
  localparam code_t SRC_R0     = 5'd0;
  localparam code_t SRC_HI     = 5'd16;
  localparam code_t SRC_LO     = 5'd17;
  localparam code_t SRC_ZHIGH  = 5'd18;
  localparam code_t SRC_ZLOW   = 5'd19;
  localparam code_t SRC_PC     = 5'd20;
  localparam code_t SRC_MDR    = 5'd21;
  localparam code_t SRC_INPORT = 5'd22;
  localparam code_t SRC_C      = 5'd23;

  // Bus destinations (in enables). Rn is DST_R0 + n for n in 0..15.
  localparam code_t DST_R0      = 5'd0;
  localparam code_t DST_HI      = 5'd16;
  localparam code_t DST_LO      = 5'd17;
  localparam code_t DST_PC      = 5'd18;
  localparam code_t DST_MDR     = 5'd19;
  localparam code_t DST_MAR     = 5'd20;
  localparam code_t DST_IR      = 5'd21;
  localparam code_t DST_Y       = 5'd22;
  localparam code_t DST_OUTPORT = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LATCH
  } xfer_state_t;

endpackage

// File: rtl/bus_xfer_sequencer_onehot_decode.sv
// Code to one-hot decoder. Codes at or above N give an all-zero vector
// and valid=0, so an illegal code can never raise a strobe.
module onehot_decode #(
  parameter int N = 24,
  parameter int W = 5
) (
  input  logic [W-1:0] code,
  output logic [N-1:0] onehot,
  output logic         valid
);

  // Decode the code into a single set bit when it is in range.
  always_comb begin
    // NOTE: every output gets a default before the conditional write, so no
    // path leaves a value unassigned and no latch is inferred.
    onehot = '0;
    valid  = 1'b0;
    if (int'(code) < N) begin
      onehot[code] = 1'b1;
      valid        = 1'b1;
    end
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Register-transfer sequencer: turns one (source, destination) request into
// a source strobe held for DRIVE_CYCLES settle cycles plus one latch cycle,
// with the destination strobe raised only in the latch cycle.
module bus_xfer_sequencer
  import bus_codes_pkg::*;
#(
  parameter int N_SRC        = N_BUS_CODES,
  parameter int N_DST        = N_BUS_CODES,
  parameter int DRIVE_CYCLES = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req_valid,
  input  logic [4:0]       req_src,
  input  logic [4:0]       req_dst,
  output logic             req_ready,
  output logic [N_SRC-1:0] out_en,
  output logic [N_DST-1:0] in_en,
  output logic             xfer_done,
  output logic             xfer_err
);

  localparam logic [3:0] DRIVE_LOAD = 4'(DRIVE_CYCLES - 1);

  xfer_state_t      state;
  logic [3:0]       cnt;
  logic [N_DST-1:0] dst_q;
  logic             err_pend;

  logic [N_SRC-1:0] src_oh;
  logic [N_DST-1:0] dst_oh;
  logic             src_ok;
  logic             dst_ok;
  logic             accept;

  onehot_decode #(.N(N_SRC), .W(5)) u_src_dec (
    .code   (req_src),
    .onehot (src_oh),
    .valid  (src_ok)
  );

  onehot_decode #(.N(N_DST), .W(5)) u_dst_dec (
    .code   (req_dst),
    .onehot (dst_oh),
    .valid  (dst_ok)
  );

  assign accept = req_valid && req_ready;

  // Transfer FSM: settle counter, captured destination and all registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // branch below reads the values from before this edge, and the later
    // assignment in a branch overrides the defaults at the top.
    if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      dst_q     <= '0;
      err_pend  <= 1'b0;
      out_en    <= '0;
      in_en     <= '0;
      xfer_done <= 1'b0;
      xfer_err  <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      xfer_done <= 1'b0;
      xfer_err  <= err_pend;
      err_pend  <= 1'b0;
      req_ready <= 1'b1;
      case (state)
        IDLE, LATCH: begin
          state     <= IDLE;
          out_en    <= '0;
          in_en     <= '0;
          xfer_done <= (state == LATCH);
          if (accept) begin
            if (src_ok && dst_ok) begin
              state     <= DRIVE;
              out_en    <= src_oh;
              dst_q     <= dst_oh;
              cnt       <= DRIVE_LOAD;
              req_ready <= 1'b0;
            end else if (state == LATCH) begin
              // The done pulse owns the next cycle, so the error pulse
              // follows one cycle later; stall new requests for that cycle
              // so the two error reports cannot merge.
              err_pend  <= 1'b1;
              req_ready <= 1'b0;
            end else begin
              xfer_err  <= 1'b1;
            end
          end
        end
        DRIVE: begin
          req_ready <= 1'b0;
          if (cnt == '0) begin
            state     <= LATCH;
            in_en     <= dst_q;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Scoreboard bench for bus_xfer_sequencer. Two lanes run the same directed
// sequence followed by random traffic, one with DRIVE_CYCLES=1 and one with
// DRIVE_CYCLES=3. The driver feeds a timeline model of expected outputs and
// a queue of expected transfer events; a monitor compares every cycle and
// pops the queue whenever the DUT shows a latch strobe or an error pulse.
module tb_bus_xfer_sequencer;
  import bus_codes_pkg::*;

  localparam int N = 24;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter: during the cycle after posedge k, cyc == k.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  bit lane_fin [2];

  typedef struct {
    bit         clr;
    int         hold;
    logic [4:0] src;
    logic [4:0] dst;
    int         idle;
    bit         change;
  } stim_t;

  typedef struct {
    int cyc;
    bit legal;
    int src;
    int dst;
  } exp_t;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(bit clr, int hold, int s, int d, int idle, bit chg);
    stim_t t;
    t.clr    = clr;
    t.hold   = hold;
    t.src    = 5'(s);
    t.dst    = 5'(d);
    t.idle   = idle;
    t.change = chg;
    return t;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int D = (g == 0) ? 1 : 3;

    logic         clear;
    logic         req_valid;
    logic [4:0]   req_src;
    logic [4:0]   req_dst;
    logic         req_ready;
    logic [N-1:0] out_en;
    logic [N-1:0] in_en;
    logic         xfer_done;
    logic         xfer_err;

    bus_xfer_sequencer #(.N_SRC(N), .N_DST(N), .DRIVE_CYCLES(D)) u_dut (
      .clock     (clock),
      .clear     (clear),
      .req_valid (req_valid),
      .req_src   (req_src),
      .req_dst   (req_dst),
      .req_ready (req_ready),
      .out_en    (out_en),
      .in_en     (in_en),
      .xfer_done (xfer_done),
      .xfer_err  (xfer_err)
    );

    // Expected outputs keyed by cycle; a missing key means 0 (ready: 1).
    logic [N-1:0] eo [int];
    logic [N-1:0] ei [int];
    bit           ed [int];
    bit           ee [int];
    bit           rl [int];
    exp_t         q [$];
    stim_t        st [$];
    int           first_rst = 32'h3fff_ffff;

    function automatic logic [N-1:0] bit_at(int k);
      logic [N-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
    endfunction

    // Reset at edge e wipes everything expected from cycle e onward.
    task automatic m_reset(int e);
      for (int k = e; k < e + 40; k++) begin
        eo.delete(k);
        ei.delete(k);
        ed.delete(k);
        ee.delete(k);
        rl.delete(k);
      end
      while (q.size() > 0 && q[$].cyc >= e) void'(q.pop_back());
    endtask

    // Request accepted at edge e: a legal one shows its source for D+1
    // cycles, its destination in the last of them, and done one cycle later;
    // busy (not ready) for the first D cycles. An illegal one pulses error
    // at e, or at e+1 when done already owns cycle e (ready drops for e).
    task automatic m_accept(int e, int s, int d);
      exp_t x;
      if (s < N_BUS_CODES && d < N_BUS_CODES) begin
        for (int k = 0; k <= D; k++) eo[e+k] = bit_at(s);
        for (int k = 0; k < D; k++) rl[e+k] = 1'b1;
        ei[e+D]   = bit_at(d);
        ed[e+D+1] = 1'b1;
        x = '{e + D, 1'b1, s, d};
      end else if (ed.exists(e)) begin
        ee[e+1] = 1'b1;
        rl[e]   = 1'b1;
        x = '{e + 1, 1'b0, s, d};
      end else begin
        ee[e] = 1'b1;
        x = '{e, 1'b0, s, d};
      end
      q.push_back(x);
    endtask

    initial begin : drive
      stim_t it;
      bit    acc;
      clear     = 1'b0;
      req_valid = 1'b0;
      req_src   = '0;
      req_dst   = '0;

      st.push_back(mk(1, 2, 0, 0, 0, 0));
      st.push_back(mk(0, 0, SRC_PC, DST_MAR, 3, 0));
      st.push_back(mk(0, 0, SRC_R0 + 3, DST_Y, 0, 0));
      st.push_back(mk(0, 0, SRC_ZLOW, DST_R0 + 7, 3, 0));
      st.push_back(mk(0, 0, 25, 2, 3, 0));
      st.push_back(mk(0, 0, SRC_R0 + 1, DST_R0 + 2, 4, 1));
      st.push_back(mk(0, 0, 5, 5, 2, 0));
      st.push_back(mk(0, 0, SRC_R0 + 1, DST_R0 + 2, 1, 0));
      st.push_back(mk(1, 1, 0, 0, 0, 0));
      st.push_back(mk(0, 0, 4, 9, 3, 0));
      st.push_back(mk(0, 0, 6, 8, 0, 0));
      st.push_back(mk(0, 0, 2, 30, 0, 0));
      st.push_back(mk(0, 0, 0, 0, 3, 0));
      for (int i = 0; i < 150; i++) begin
        int s, d;
        s = ($urandom_range(0, 19) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
        d = ($urandom_range(0, 19) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
        if ($urandom_range(0, 24) == 0)
          st.push_back(mk(1, int'($urandom_range(1, 2)), 0, 0, 0, 0));
        else
          st.push_back(mk(0, 0, s, d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1))));
      end

      @(negedge clock);
      foreach (st[i]) begin
        it = st[i];
        if (it.clr) begin
          for (int k = 0; k < it.hold; k++) begin
            clear     = 1'b1;
            req_valid = 1'b1;
            req_src   = 5'($urandom_range(0, 23));
            req_dst   = 5'($urandom_range(0, 23));
            if (first_rst > cyc + 1) first_rst = cyc + 1;
            m_reset(cyc + 1);
            @(negedge clock);
          end
          clear     = 1'b0;
          req_valid = 1'b0;
        end else begin
          req_valid = 1'b1;
          req_src   = it.src;
          req_dst   = it.dst;
          acc       = 1'b0;
          for (int w = 0; w < 64 && !acc; w++) begin
            if (!rl.exists(cyc)) begin
              acc = 1'b1;
              m_accept(cyc + 1, int'(it.src), int'(it.dst));
            end
            @(negedge clock);
          end
          if (!acc) check($sformatf("d%0d.accept_timeout", D), 64'd0, 64'd1);
          for (int k = 0; k < it.idle; k++) begin
            req_valid = 1'b0;
            if (it.change) begin
              req_src = 5'($urandom_range(0, 31));
              req_dst = 5'($urandom_range(0, 31));
            end
            @(negedge clock);
          end
        end
      end
      req_valid = 1'b0;
      repeat (D + 4) @(negedge clock);
      check($sformatf("d%0d.queue_drained", D), 64'(q.size()), 64'd0);
      lane_fin[g] = 1'b1;
    end

    // Monitor: compare every cycle's outputs and pop an event when one shows.
    always @(negedge clock) begin : mon
      exp_t x;
      int   e;
      e = cyc;
      if (e >= first_rst) begin
        check($sformatf("d%0d.out_en@%0d", D, e), 64'(out_en), 64'(eo.exists(e) ? eo[e] : '0));
        check($sformatf("d%0d.in_en@%0d", D, e), 64'(in_en), 64'(ei.exists(e) ? ei[e] : '0));
        check($sformatf("d%0d.xfer_done@%0d", D, e), 64'(xfer_done), 64'(ed.exists(e)));
        check($sformatf("d%0d.xfer_err@%0d", D, e), 64'(xfer_err), 64'(ee.exists(e)));
        check($sformatf("d%0d.req_ready@%0d", D, e), 64'(req_ready), 64'(!rl.exists(e)));
        if (in_en != '0 || xfer_err) begin
          if (q.size() == 0) begin
            check($sformatf("d%0d.orphan_event@%0d", D, e), 64'd1, 64'd0);
          end else begin
            x = q.pop_front();
            check($sformatf("d%0d.event_cycle", D), 64'(e), 64'(x.cyc));
            check($sformatf("d%0d.event_kind@%0d", D, e), 64'(in_en != '0), 64'(x.legal));
          end
        end
      end
    end
  end

  initial begin
    fork
      wait (lane_fin[0] && lane_fin[1]);
      begin
        #500_000;
        n_bad++;
        $display("FAIL watchdog: got lanes still running, want both finished");
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
